// File: rtl/mul_iter_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_iter_seq_pkg : state encoding and latency constants for the sequencer |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package mul_iter_seq_pkg;

  typedef logic [2:0] seq_state_t;

  localparam seq_state_t S_IDLE    = 3'd0;
  localparam seq_state_t S_RD_OPS  = 3'd1;
  localparam seq_state_t S_LAT_OPS = 3'd2;
  localparam seq_state_t S_WR_TMP  = 3'd3;
  localparam seq_state_t S_RD_TMP  = 3'd4;
  localparam seq_state_t S_LAT_TMP = 3'd5;
  localparam seq_state_t S_WR_DST  = 3'd6;
  localparam seq_state_t S_DONE    = 3'd7;

  // done rises SEQ_FIXED_LAT + SEQ_ITER_LAT*N cycles after the start edge
  localparam int SEQ_FIXED_LAT = 4;
  localparam int SEQ_ITER_LAT  = 3;

endpackage
`default_nettype wire

// File: rtl/mul_iter_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mul_iter_seq : register-file sequencer computing dst = Rs^N * Rm          |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mul_iter_seq
  import mul_iter_seq_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4,
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_a_addr,
  input  logic [AW-1:0] src_b_addr,
  input  logic [AW-1:0] tmp_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [CW-1:0] iter_n,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] in_address_1,
  output logic [AW-1:0] in_address_2,
  output logic [AW-1:0] in_address_3,
  output logic          read_enable_1,
  output logic          read_enable_2,
  output logic          read_enable_3,
  input  logic [DW-1:0] out_data_1,
  input  logic [DW-1:0] out_data_2,
  input  logic [DW-1:0] out_data_3,
  output logic [AW-1:0] write_address_3,
  output logic [AW-1:0] write_address_4,
  output logic          write_enable_3,
  output logic          write_enable_4,
  output logic [DW-1:0] write_data_3,
  output logic [DW-1:0] write_data_4,
  output logic [DW-1:0] mul_rs,
  output logic [DW-1:0] mul_rm,
  input  logic [DW-1:0] mul_result
);

  seq_state_t    state;
  seq_state_t    state_nxt;
  logic [CW-1:0] count;
  logic [AW-1:0] a_q;
  logic [AW-1:0] b_q;
  logic [AW-1:0] tmp_q;
  logic [AW-1:0] dst_q;

  // State, iteration count, latched addresses and multiplier operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      count  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      tmp_q  <= '0;
      dst_q  <= '0;
      mul_rs <= '0;
      mul_rm <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= src_a_addr;
            b_q   <= src_b_addr;
            tmp_q <= tmp_addr;
            dst_q <= dst_addr;
            count <= iter_n;
          end
        end
        S_LAT_OPS: begin
          mul_rs <= out_data_1;
          mul_rm <= out_data_2;
        end
        S_LAT_TMP: begin
          mul_rm <= out_data_3;
          count  <= count - CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_RD_OPS;
      S_RD_OPS:  state_nxt = S_LAT_OPS;
      S_LAT_OPS: state_nxt = (count == '0) ? S_WR_DST : S_WR_TMP;
      S_WR_TMP:  state_nxt = S_RD_TMP;
      S_RD_TMP:  state_nxt = S_LAT_TMP;
      // count is decremented on this same edge, so test against one
      S_LAT_TMP: state_nxt = (count == CW'(1)) ? S_WR_DST : S_WR_TMP;
      S_WR_DST:  state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy            = (state != S_IDLE);
    done            = 1'b0;
    in_address_1    = '0;
    in_address_2    = '0;
    in_address_3    = '0;
    read_enable_1   = 1'b0;
    read_enable_2   = 1'b0;
    read_enable_3   = 1'b0;
    write_address_3 = '0;
    write_address_4 = '0;
    write_enable_3  = 1'b0;
    write_enable_4  = 1'b0;
    write_data_3    = '0;
    write_data_4    = '0;
    case (state)
      S_RD_OPS: begin
        read_enable_1 = 1'b1;
        read_enable_2 = 1'b1;
        in_address_1  = a_q;
        in_address_2  = b_q;
      end
      S_WR_TMP: begin
        write_enable_3  = 1'b1;
        write_address_3 = tmp_q;
        write_data_3    = mul_result;
      end
      S_RD_TMP: begin
        read_enable_3 = 1'b1;
        in_address_3  = tmp_q;
      end
      S_WR_DST: begin
        write_enable_4  = 1'b1;
        write_address_4 = dst_q;
        write_data_4    = mul_rm;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_iter_seq.sv
`default_nettype none
// Self-checking bench for mul_iter_seq with a register-file and multiplier model.
module tb_mul_iter_seq;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 6;
  localparam int TIMEOUT = 300;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] src_a_addr, src_b_addr, tmp_addr, dst_addr;
  logic [CW-1:0] iter_n;
  logic          busy, done;
  logic [AW-1:0] in_address_1, in_address_2, in_address_3;
  logic          read_enable_1, read_enable_2, read_enable_3;
  logic [DW-1:0] out_data_1, out_data_2, out_data_3;
  logic [AW-1:0] write_address_3, write_address_4;
  logic          write_enable_3, write_enable_4;
  logic [DW-1:0] write_data_3, write_data_4;
  logic [DW-1:0] mul_rs, mul_rm, mul_result;

  int checks = 0;
  int failures = 0;

  mul_iter_seq #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
    .tmp_addr(tmp_addr), .dst_addr(dst_addr), .iter_n(iter_n),
    .busy(busy), .done(done),
    .in_address_1(in_address_1), .in_address_2(in_address_2), .in_address_3(in_address_3),
    .read_enable_1(read_enable_1), .read_enable_2(read_enable_2), .read_enable_3(read_enable_3),
    .out_data_1(out_data_1), .out_data_2(out_data_2), .out_data_3(out_data_3),
    .write_address_3(write_address_3), .write_address_4(write_address_4),
    .write_enable_3(write_enable_3), .write_enable_4(write_enable_4),
    .write_data_3(write_data_3), .write_data_4(write_data_4),
    .mul_rs(mul_rs), .mul_rm(mul_rm), .mul_result(mul_result)
  );

  always #5 clk = ~clk;

  // reg_sync model: registered reads, writes on the rising edge, plus a load port
  logic [DW-1:0] rf [16];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  always @(posedge clk) begin
    if (read_enable_1) out_data_1 <= rf[in_address_1];
    if (read_enable_2) out_data_2 <= rf[in_address_2];
    if (read_enable_3) out_data_3 <= rf[in_address_3];
    if (write_enable_3) rf[write_address_3] <= write_data_3;
    if (write_enable_4) rf[write_address_4] <= write_data_4;
    if (ld_en) rf[ld_addr] <= ld_data;
  end

  assign mul_result = mul_rs * mul_rm;

  function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] rs, input logic [DW-1:0] rm,
                                               input int n);
    logic [DW-1:0] r;
    r = rm;
    for (int i = 0; i < n; i++) r = r * rs;
    return r;
  endfunction

  task automatic load_rf(input int idx, input logic [DW-1:0] val);
    @(negedge clk);
    ld_en = 1'b1;
    ld_addr = AW'(idx);
    ld_data = val;
    @(posedge clk);
    #1 ld_en = 1'b0;
  endtask

  // Starts one operation and follows it to done; addresses are scrambled while busy.
  task automatic run_op(input int a, input int b, input int t, input int d, input int n,
                        output int lat, output int we3, output int busy_cyc, output bit to);
    @(negedge clk);
    src_a_addr = AW'(a); src_b_addr = AW'(b); tmp_addr = AW'(t); dst_addr = AW'(d);
    iter_n = CW'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; we3 = 0; busy_cyc = 0; to = 1'b1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      if (busy) busy_cyc++;
      if (write_enable_3) we3++;
      src_a_addr = AW'($urandom); src_b_addr = AW'($urandom);
      tmp_addr = AW'($urandom); dst_addr = AW'($urandom); iter_n = CW'($urandom);
      if (done) begin
        lat = c;
        to = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    src_a_addr = '0; src_b_addr = '0; tmp_addr = '0; dst_addr = '0; iter_n = '0;
    for (int i = 0; i < 16; i++) load_rf(i, '0);
    @(negedge clk);
    checks++;
    if ({busy, done} !== 2'b00) begin
      failures++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done});
    end
    checks++;
    if ({read_enable_1, read_enable_2, read_enable_3, write_enable_3, write_enable_4} !== 5'b0) begin
      failures++; $display("FAIL reset_enables got=%b exp=00000",
        {read_enable_1, read_enable_2, read_enable_3, write_enable_3, write_enable_4});
    end
    checks++;
    if ({in_address_1, in_address_2, in_address_3, write_address_3, write_address_4,
         write_data_3, write_data_4, mul_rs, mul_rm} !== '0) begin
      failures++; $display("FAIL reset_addr_data got rs=%h rm=%h wd3=%h wd4=%h exp=0",
        mul_rs, mul_rm, write_data_3, write_data_4);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    int lat, we3, bc;
    bit to;
    // T1: 2^30 through 30 iterations
    load_rf(0, 32'd2); load_rf(1, 32'd1);
    run_op(0, 1, 2, 3, 30, lat, we3, bc, to);
    checks++;
    if (to || lat != 94) begin failures++; $display("FAIL t1_latency got=%0d exp=94 timeout=%0b", lat, to); end
    checks++;
    if (rf[3] !== 32'h4000_0000) begin failures++; $display("FAIL t1_dst got=%h exp=40000000", rf[3]); end
    checks++;
    if (rf[2] !== 32'h4000_0000) begin failures++; $display("FAIL t1_tmp got=%h exp=40000000", rf[2]); end
    checks++;
    if (we3 != 30) begin failures++; $display("FAIL t1_tmp_writes got=%0d exp=30", we3); end
    // T2: single iteration
    load_rf(0, 32'd3); load_rf(1, 32'd5);
    run_op(0, 1, 2, 3, 1, lat, we3, bc, to);
    checks++;
    if (to || lat != 7) begin failures++; $display("FAIL t2_latency got=%0d exp=7", lat); end
    checks++;
    if (bc != 7) begin failures++; $display("FAIL t2_busy_cycles got=%0d exp=7", bc); end
    checks++;
    if (rf[3] !== 32'd15) begin failures++; $display("FAIL t2_dst got=%h exp=f", rf[3]); end
    // T3: N=0 copies Rm
    load_rf(1, 32'hDEAD_BEEF);
    run_op(0, 1, 2, 3, 0, lat, we3, bc, to);
    checks++;
    if (to || lat != 4) begin failures++; $display("FAIL t3_latency got=%0d exp=4", lat); end
    checks++;
    if (we3 != 0) begin failures++; $display("FAIL t3_tmp_writes got=%0d exp=0", we3); end
    checks++;
    if (rf[3] !== 32'hDEAD_BEEF) begin failures++; $display("FAIL t3_dst got=%h exp=deadbeef", rf[3]); end
    // T4: truncation to zero
    load_rf(0, 32'h0001_0000); load_rf(1, 32'd1);
    run_op(0, 1, 2, 3, 2, lat, we3, bc, to);
    checks++;
    if (to || rf[3] !== 32'd0) begin failures++; $display("FAIL t4_dst got=%h exp=0", rf[3]); end
    checks++;
    if (rf[2] !== 32'd0) begin failures++; $display("FAIL t4_tmp got=%h exp=0", rf[2]); end
  endtask

  task automatic test_alias;
    int lat, we3, bc;
    bit to;
    logic [DW-1:0] exp;
    // tmp overlaps Rs: operands must be captured before the first temp write
    load_rf(4, 32'd7); load_rf(5, 32'd11);
    exp = ref_result(32'd7, 32'd11, 3);
    run_op(4, 5, 4, 6, 3, lat, we3, bc, to);
    checks++;
    if (to || rf[6] !== exp) begin failures++; $display("FAIL alias_tmp_src got=%h exp=%h", rf[6], exp); end
    // tmp equals dst
    load_rf(4, 32'd13); load_rf(5, 32'd3);
    exp = ref_result(32'd13, 32'd3, 4);
    run_op(4, 5, 7, 7, 4, lat, we3, bc, to);
    checks++;
    if (to || rf[7] !== exp) begin failures++; $display("FAIL alias_tmp_dst got=%h exp=%h", rf[7], exp); end
  endtask

  task automatic test_random;
    int lat, we3, bc, a, b, t, d, n, bad;
    bit to;
    logic [DW-1:0] exp_rf [16];
    logic [DW-1:0] res;
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 16; i++) load_rf(i, DW'($urandom));
      @(negedge clk);
      a = $urandom_range(0, 15); b = $urandom_range(0, 15);
      t = $urandom_range(0, 15); d = $urandom_range(0, 15);
      n = (k == 7) ? 63 : $urandom_range(0, 10);
      for (int i = 0; i < 16; i++) exp_rf[i] = rf[i];
      res = ref_result(exp_rf[a], exp_rf[b], n);
      if (n > 0) exp_rf[t] = res;
      exp_rf[d] = res;
      run_op(a, b, t, d, n, lat, we3, bc, to);
      checks++;
      if (to || lat != 3 * n + 4) begin
        failures++; $display("FAIL rand_latency op=%0d n=%0d got=%0d exp=%0d", k, n, lat, 3 * n + 4);
      end
      checks++;
      if (rf[d] !== res) begin failures++; $display("FAIL rand_dst op=%0d got=%h exp=%h", k, rf[d], res); end
      bad = 0;
      for (int i = 0; i < 16; i++) if (rf[i] !== exp_rf[i]) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL rand_regfile op=%0d wrong_regs got=%0d exp=0", k, bad); end
    end
  endtask

  task automatic test_restart_ignored;
    int dones, done_at, lat, we3, bc;
    bit to;
    logic [DW-1:0] exp;
    load_rf(0, 32'd6); load_rf(1, 32'd9);
    exp = ref_result(32'd6, 32'd9, 2);
    @(negedge clk);
    src_a_addr = 4'd0; src_b_addr = 4'd1; tmp_addr = 4'd2; dst_addr = 4'd3; iter_n = 6'd2;
    start = 1'b1;
    dones = 0; done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 5);
      if (done) begin dones++; done_at = c; end
    end
    start = 1'b0;
    checks++;
    if (dones != 1 || done_at != 10) begin
      failures++; $display("FAIL restart_done_count got=%0d@%0d exp=1@10", dones, done_at);
    end
    checks++;
    if (rf[3] !== exp) begin failures++; $display("FAIL restart_dst got=%h exp=%h", rf[3], exp); end
    run_op(0, 1, 2, 5, 1, lat, we3, bc, to);
    checks++;
    if (to || rf[5] !== 32'd54) begin failures++; $display("FAIL restart_next got=%h exp=36", rf[5]); end
  endtask

  task automatic test_reset_mid;
    int lat, we3, bc;
    bit to;
    load_rf(0, 32'd3); load_rf(1, 32'd2); load_rf(3, 32'h1234_5678);
    @(negedge clk);
    src_a_addr = 4'd0; src_b_addr = 4'd1; tmp_addr = 4'd2; dst_addr = 4'd3; iter_n = 6'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, read_enable_1, read_enable_2, read_enable_3, write_enable_3, write_enable_4} !== 7'b0) begin
      failures++; $display("FAIL midreset_ctrl got=%b exp=0000000",
        {busy, done, read_enable_1, read_enable_2, read_enable_3, write_enable_3, write_enable_4});
    end
    checks++;
    if ({mul_rs, mul_rm} !== '0) begin
      failures++; $display("FAIL midreset_operands got rs=%h rm=%h exp=0", mul_rs, mul_rm);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (rf[3] !== 32'h1234_5678) begin failures++; $display("FAIL midreset_dst got=%h exp=12345678", rf[3]); end
    run_op(0, 1, 2, 3, 4, lat, we3, bc, to);
    checks++;
    if (to || rf[3] !== 32'd162) begin failures++; $display("FAIL midreset_recover got=%h exp=a2", rf[3]); end
  endtask

  task automatic test_back_to_back;
    int lat, we3, bc;
    bit to;
    load_rf(8, 32'd5); load_rf(9, 32'd4);
    run_op(8, 9, 10, 11, 2, lat, we3, bc, to);
    run_op(8, 11, 10, 12, 1, lat, we3, bc, to);
    checks++;
    if (to || lat != 7) begin failures++; $display("FAIL b2b_latency got=%0d exp=7", lat); end
    checks++;
    if (rf[12] !== 32'd500) begin failures++; $display("FAIL b2b_dst got=%h exp=1f4", rf[12]); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_alias();
    test_random();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
